// File: rtl/alu_reservation_station_if.sv
// Bundle of dispatch, CDB, ALU and result signals for the ALU reservation station.
// slave: station side; master: environment side (dispatch, CDB, ALU, writeback).
interface alu_reservation_station_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  dispatch_valid;
    logic                  dispatch_ready;
    logic [TAG_WIDTH-1:0]  dispatch_tag;
    logic [DATA_WIDTH-1:0] dispatch_lhs;
    logic [DATA_WIDTH-1:0] dispatch_rhs;
    logic                  dispatch_lhs_valid;
    logic                  dispatch_rhs_valid;
    logic [TAG_WIDTH-1:0]  dispatch_lhs_tag;
    logic [TAG_WIDTH-1:0]  dispatch_rhs_tag;
    logic                  dispatch_uses_imm;
    logic [2:0]            dispatch_funct3;
    logic [6:0]            dispatch_funct7;
    logic                  cdb_valid;
    logic [TAG_WIDTH-1:0]  cdb_tag;
    logic [DATA_WIDTH-1:0] cdb_data;
    logic [DATA_WIDTH-1:0] alu_lhs;
    logic [DATA_WIDTH-1:0] alu_rhs;
    logic                  alu_lhs_valid;
    logic                  alu_rhs_valid;
    logic                  alu_uses_imm;
    logic [2:0]            alu_funct3;
    logic [6:0]            alu_funct7;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_result_valid;
    logic                  out_valid;
    logic                  out_ready;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_illegal;
    logic [CW-1:0]         occupancy;

    modport slave (
        input  flush, dispatch_valid, dispatch_tag,
        input  dispatch_lhs, dispatch_rhs,
        input  dispatch_lhs_valid, dispatch_rhs_valid,
        input  dispatch_lhs_tag, dispatch_rhs_tag,
        input  dispatch_uses_imm, dispatch_funct3, dispatch_funct7,
        input  cdb_valid, cdb_tag, cdb_data,
        input  alu_result, alu_result_valid, out_ready,
        output dispatch_ready,
        output alu_lhs, alu_rhs, alu_lhs_valid, alu_rhs_valid,
        output alu_uses_imm, alu_funct3, alu_funct7,
        output out_valid, out_tag, out_data, out_illegal, occupancy
    );

    modport master (
        output flush, dispatch_valid, dispatch_tag,
        output dispatch_lhs, dispatch_rhs,
        output dispatch_lhs_valid, dispatch_rhs_valid,
        output dispatch_lhs_tag, dispatch_rhs_tag,
        output dispatch_uses_imm, dispatch_funct3, dispatch_funct7,
        output cdb_valid, cdb_tag, cdb_data,
        output alu_result, alu_result_valid, out_ready,
        input  dispatch_ready,
        input  alu_lhs, alu_rhs, alu_lhs_valid, alu_rhs_valid,
        input  alu_uses_imm, alu_funct3, alu_funct7,
        input  out_valid, out_tag, out_data, out_illegal, occupancy
    );
endinterface

// File: rtl/alu_reservation_station.sv
// Out-of-order issue buffer for the shared ALU: captures operands from the CDB,
// issues the oldest ready entry, registers result+tag. Ports: clk, rst_n, io (slave).
module alu_reservation_station #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_reservation_station_if.slave io
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] lhs;
        logic [DATA_WIDTH-1:0] rhs;
        logic                  lhs_rdy;
        logic                  rhs_rdy;
        logic [TAG_WIDTH-1:0]  lhs_tag;
        logic [TAG_WIDTH-1:0]  rhs_tag;
        logic                  uses_imm;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
    } entry_t;

    // Slots 0..count_q-1 are valid; slot 0 is the oldest.
    entry_t                ent_q [DEPTH];
    entry_t                woke  [DEPTH];
    entry_t                ent_n [DEPTH];
    entry_t                new_e;
    entry_t                sel_e;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_n;
    logic [CW-1:0]         sel_idx;
    logic [CW-1:0]         ins_idx;
    logic                  sel_found;
    logic                  issue;
    logic                  accept;
    logic                  disp_ready;
    logic                  out_valid_q;
    logic [TAG_WIDTH-1:0]  out_tag_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_illegal_q;

    assign disp_ready = (count_q != CW'(DEPTH));
    assign accept     = io.dispatch_valid && disp_ready && !io.flush;
    assign issue      = sel_found && (!out_valid_q || io.out_ready) && !io.flush;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            if (io.cdb_valid && !ent_q[i].lhs_rdy &&
                ent_q[i].lhs_tag == io.cdb_tag) begin
                woke[i].lhs     = io.cdb_data;
                woke[i].lhs_rdy = 1'b1;
            end
            if (io.cdb_valid && !ent_q[i].rhs_rdy &&
                ent_q[i].rhs_tag == io.cdb_tag) begin
                woke[i].rhs     = io.cdb_data;
                woke[i].rhs_rdy = 1'b1;
            end
        end
    end

    // Readiness uses registered state, so a wakeup takes effect next cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_e     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && CW'(i) < count_q &&
                ent_q[i].lhs_rdy && ent_q[i].rhs_rdy) begin
                sel_found = 1'b1;
                sel_idx   = CW'(i);
                sel_e     = ent_q[i];
            end
        end
    end

    always_comb begin
        new_e          = '0;
        new_e.tag      = io.dispatch_tag;
        new_e.lhs_tag  = io.dispatch_lhs_tag;
        new_e.rhs_tag  = io.dispatch_rhs_tag;
        new_e.uses_imm = io.dispatch_uses_imm;
        new_e.funct3   = io.dispatch_funct3;
        new_e.funct7   = io.dispatch_funct7;
        unique case (1'b1)
            io.dispatch_lhs_valid: begin
                new_e.lhs     = io.dispatch_lhs;
                new_e.lhs_rdy = 1'b1;
            end
            io.cdb_valid && io.cdb_tag == io.dispatch_lhs_tag: begin
                new_e.lhs     = io.cdb_data;
                new_e.lhs_rdy = 1'b1;
            end
            default: ;
        endcase
        unique case (1'b1)
            io.dispatch_rhs_valid: begin
                new_e.rhs     = io.dispatch_rhs;
                new_e.rhs_rdy = 1'b1;
            end
            io.cdb_valid && io.cdb_tag == io.dispatch_rhs_tag: begin
                new_e.rhs     = io.cdb_data;
                new_e.rhs_rdy = 1'b1;
            end
            default: ;
        endcase
    end

    // Issue closes the gap by shifting younger entries down; the new
    // entry lands just past the surviving ones.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_n[i] = woke[i];
        end
        if (issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (CW'(i) >= sel_idx) begin
                    ent_n[i] = woke[i+1];
                end
            end
        end
        ins_idx = count_q - CW'(issue);
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == ins_idx) begin
                    ent_n[i] = new_e;
                end
            end
        end
        if (io.flush) begin
            count_n = '0;
        end else begin
            count_n = count_q + CW'(accept) - CW'(issue);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_tag_q     <= '0;
            out_data_q    <= '0;
            out_illegal_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_n;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_n[i];
            end
            if (io.flush) begin
                out_valid_q <= 1'b0;
            end else if (issue) begin
                out_valid_q   <= 1'b1;
                out_tag_q     <= sel_e.tag;
                out_illegal_q <= !io.alu_result_valid;
                out_data_q    <= io.alu_result_valid ? io.alu_result : '0;
            end else if (out_valid_q && io.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign io.dispatch_ready = disp_ready;
    assign io.alu_lhs        = sel_e.lhs;
    assign io.alu_rhs        = sel_e.rhs;
    assign io.alu_lhs_valid  = sel_found;
    assign io.alu_rhs_valid  = sel_found;
    assign io.alu_uses_imm   = sel_e.uses_imm;
    assign io.alu_funct3     = sel_e.funct3;
    assign io.alu_funct7     = sel_e.funct7;
    assign io.out_valid      = out_valid_q;
    assign io.out_tag        = out_tag_q;
    assign io.out_data       = out_data_q;
    assign io.out_illegal    = out_illegal_q;
    assign io.occupancy      = count_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with a small behavioural ALU.
// Table of single-op vectors plus hand sequences for wakeup, order, full, flush, reset.
module tb_alu_reservation_station;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_reservation_station_if #(
        .DATA_WIDTH(64), .DEPTH(4), .TAG_WIDTH(4)
    ) io ();

    alu_reservation_station #(
        .DATA_WIDTH(64), .DEPTH(4), .TAG_WIDTH(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Small ALU: ADD/SUB/ADDI, XOR, OR, AND; anything else is illegal.
    always_comb begin
        io.alu_result       = '0;
        io.alu_result_valid = 1'b0;
        if (io.alu_lhs_valid && io.alu_rhs_valid) begin
            case (io.alu_funct3)
                3'd0: begin
                    if (io.alu_uses_imm || io.alu_funct7 == 7'h00) begin
                        io.alu_result       = io.alu_lhs + io.alu_rhs;
                        io.alu_result_valid = 1'b1;
                    end else if (io.alu_funct7 == 7'h20) begin
                        io.alu_result       = io.alu_lhs - io.alu_rhs;
                        io.alu_result_valid = 1'b1;
                    end
                end
                3'd4: if (io.alu_funct7 == 7'h00) begin
                    io.alu_result       = io.alu_lhs ^ io.alu_rhs;
                    io.alu_result_valid = 1'b1;
                end
                3'd6: if (io.alu_funct7 == 7'h00) begin
                    io.alu_result       = io.alu_lhs | io.alu_rhs;
                    io.alu_result_valid = 1'b1;
                end
                3'd7: if (io.alu_funct7 == 7'h00) begin
                    io.alu_result       = io.alu_lhs & io.alu_rhs;
                    io.alu_result_valid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] tag,
                        input logic lv, input logic [63:0] l,
                        input logic [3:0] lt,
                        input logic rv, input logic [63:0] r,
                        input logic [3:0] rt,
                        input logic imm, input logic [2:0] f3,
                        input logic [6:0] f7);
        io.dispatch_valid     = 1'b1;
        io.dispatch_tag       = tag;
        io.dispatch_lhs_valid = lv;
        io.dispatch_lhs       = l;
        io.dispatch_lhs_tag   = lt;
        io.dispatch_rhs_valid = rv;
        io.dispatch_rhs       = r;
        io.dispatch_rhs_tag   = rt;
        io.dispatch_uses_imm  = imm;
        io.dispatch_funct3    = f3;
        io.dispatch_funct7    = f7;
    endtask

    task automatic idle();
        io.dispatch_valid     = 1'b0;
        io.dispatch_tag       = '0;
        io.dispatch_lhs_valid = 1'b0;
        io.dispatch_lhs       = '0;
        io.dispatch_lhs_tag   = '0;
        io.dispatch_rhs_valid = 1'b0;
        io.dispatch_rhs       = '0;
        io.dispatch_rhs_tag   = '0;
        io.dispatch_uses_imm  = 1'b0;
        io.dispatch_funct3    = '0;
        io.dispatch_funct7    = '0;
    endtask

    task automatic cdb(input logic v, input logic [3:0] t,
                       input logic [63:0] d);
        io.cdb_valid = v;
        io.cdb_tag   = t;
        io.cdb_data  = d;
    endtask

    typedef struct {
        logic        imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  tag;
        logic [63:0] exp;
        logic        ill;
    } vec_t;

    vec_t vt [7];

    initial begin
        checks = 0;
        errors = 0;
        vt[0] = '{1'b0, 3'd0, 7'h00, 64'd5, 64'd7, 4'd1, 64'd12, 1'b0};
        vt[1] = '{1'b0, 3'd0, 7'h20, 64'd100, 64'd40, 4'd2, 64'd60, 1'b0};
        vt[2] = '{1'b0, 3'd7, 7'h00, 64'hF0, 64'h3C, 4'd3, 64'h30, 1'b0};
        vt[3] = '{1'b1, 3'd0, 7'h00, '1, 64'd1, 4'd4, 64'd0, 1'b0};
        vt[4] = '{1'b0, 3'd0, 7'h7f, 64'd9, 64'd9, 4'd5, 64'd0, 1'b1};
        vt[5] = '{1'b0, 3'd0, 7'h20, 64'd0, 64'd1, 4'd6, '1, 1'b0};
        vt[6] = '{1'b0, 3'd4, 7'h00, 64'hFF00, 64'h0FF0, 4'd15,
                  64'hF0F0, 1'b0};

        rst_n        = 1'b0;
        io.flush     = 1'b0;
        io.out_ready = 1'b1;
        idle();
        cdb(1'b0, 4'd0, 64'd0);
        #3;
        chk("rst_occupancy", 64'(io.occupancy), 64'd0);
        chk("rst_out_valid", 64'(io.out_valid), 64'd0);
        chk("rst_out_tag", 64'(io.out_tag), 64'd0);
        chk("rst_out_data", io.out_data, 64'd0);
        chk("rst_out_illegal", 64'(io.out_illegal), 64'd0);
        chk("rst_alu_valid", 64'(io.alu_lhs_valid), 64'd0);
        chk("rst_alu_lhs", io.alu_lhs, 64'd0);
        chk("rst_disp_ready", 64'(io.dispatch_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            disp(vt[v].tag, 1'b1, vt[v].a, 4'd0, 1'b1, vt[v].b, 4'd0,
                 vt[v].imm, vt[v].f3, vt[v].f7);
            tick();
            idle();
            chk($sformatf("v%0d_occ1", v), 64'(io.occupancy), 64'd1);
            chk($sformatf("v%0d_early", v), 64'(io.out_valid), 64'd0);
            tick();
            chk($sformatf("v%0d_valid", v), 64'(io.out_valid), 64'd1);
            chk($sformatf("v%0d_data", v), io.out_data, vt[v].exp);
            chk($sformatf("v%0d_tag", v), 64'(io.out_tag), 64'(vt[v].tag));
            chk($sformatf("v%0d_ill", v), 64'(io.out_illegal),
                64'(vt[v].ill));
            chk($sformatf("v%0d_occ0", v), 64'(io.occupancy), 64'd0);
            tick();
            chk($sformatf("v%0d_drain", v), 64'(io.out_valid), 64'd0);
        end

        // Dependent wakeup: rhs waits on tag 3.
        disp(4'd5, 1'b1, 64'd100, 4'd0, 1'b0, 64'd0, 4'd3,
             1'b0, 3'd0, 7'h20);
        tick();
        idle();
        chk("dep_not_sel", 64'(io.alu_lhs_valid), 64'd0);
        tick();
        chk("dep_no_issue", 64'(io.out_valid), 64'd0);
        cdb(1'b1, 4'd3, 64'd40);
        tick();
        cdb(1'b0, 4'd0, 64'd0);
        chk("dep_no_issue2", 64'(io.out_valid), 64'd0);
        chk("dep_sel", 64'(io.alu_lhs_valid), 64'd1);
        chk("dep_alu_rhs", io.alu_rhs, 64'd40);
        chk("dep_alu_f7", 64'(io.alu_funct7), 64'h20);
        tick();
        chk("dep_valid", 64'(io.out_valid), 64'd1);
        chk("dep_data", io.out_data, 64'd60);
        chk("dep_tag", 64'(io.out_tag), 64'd5);
        tick();

        // Age order and dispatch bypass.
        disp(4'd1, 1'b1, 64'd10, 4'd0, 1'b0, 64'd0, 4'd9,
             1'b0, 3'd0, 7'h00);
        tick();
        disp(4'd2, 1'b1, 64'd3, 4'd0, 1'b1, 64'd4, 4'd0,
             1'b0, 3'd0, 7'h00);
        tick();
        idle();
        chk("age_occ2", 64'(io.occupancy), 64'd2);
        tick();
        chk("age_b_tag", 64'(io.out_tag), 64'd2);
        chk("age_b_data", io.out_data, 64'd7);
        chk("age_occ1", 64'(io.occupancy), 64'd1);
        cdb(1'b1, 4'd9, 64'd20);
        disp(4'd4, 1'b1, 64'd1, 4'd0, 1'b0, 64'd0, 4'd9,
             1'b0, 3'd0, 7'h00);
        tick();
        idle();
        cdb(1'b0, 4'd0, 64'd0);
        chk("age_occ2b", 64'(io.occupancy), 64'd2);
        chk("age_gap", 64'(io.out_valid), 64'd0);
        tick();
        chk("age_a_tag", 64'(io.out_tag), 64'd1);
        chk("age_a_data", io.out_data, 64'd30);
        tick();
        chk("age_c_tag", 64'(io.out_tag), 64'd4);
        chk("age_c_data", io.out_data, 64'd21);
        tick();
        chk("age_empty", 64'(io.occupancy), 64'd0);
        chk("age_drain", 64'(io.out_valid), 64'd0);

        // Full and backpressure.
        io.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            disp(4'(8 + k), 1'b1, 64'(k + 1), 4'd0, 1'b1, 64'd10, 4'd0,
                 1'b0, 3'd0, 7'h00);
            tick();
        end
        chk("full_ready", 64'(io.dispatch_ready), 64'd0);
        chk("full_occ", 64'(io.occupancy), 64'd4);
        chk("full_out_tag", 64'(io.out_tag), 64'd8);
        chk("full_out_data", io.out_data, 64'd11);
        disp(4'd13, 1'b1, 64'd50, 4'd0, 1'b1, 64'd50, 4'd0,
             1'b0, 3'd0, 7'h00);
        tick();
        idle();
        chk("hold_occ", 64'(io.occupancy), 64'd4);
        chk("hold_valid", 64'(io.out_valid), 64'd1);
        chk("hold_tag", 64'(io.out_tag), 64'd8);
        chk("hold_data", io.out_data, 64'd11);
        io.out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk($sformatf("drain%0d_tag", k), 64'(io.out_tag), 64'(8 + k));
            chk($sformatf("drain%0d_data", k), io.out_data, 64'(11 + k));
        end
        chk("drain_occ", 64'(io.occupancy), 64'd0);
        tick();
        chk("drain_valid", 64'(io.out_valid), 64'd0);

        // Flush with a same-cycle dispatch.
        io.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(4'(1 + k), 1'b1, 64'd1, 4'd0, 1'b1, 64'd1, 4'd0,
                 1'b0, 3'd0, 7'h00);
            tick();
        end
        chk("pre_flush_occ", 64'(io.occupancy), 64'd3);
        chk("pre_flush_valid", 64'(io.out_valid), 64'd1);
        disp(4'd14, 1'b1, 64'd2, 4'd0, 1'b1, 64'd2, 4'd0,
             1'b0, 3'd0, 7'h00);
        io.flush = 1'b1;
        tick();
        io.flush = 1'b0;
        idle();
        chk("flush_occ", 64'(io.occupancy), 64'd0);
        chk("flush_valid", 64'(io.out_valid), 64'd0);
        io.out_ready = 1'b1;
        tick();
        chk("flush_absent", 64'(io.out_valid), 64'd0);
        chk("flush_occ2", 64'(io.occupancy), 64'd0);

        // Asynchronous reset mid-cycle.
        io.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(4'(1 + k), 1'b1, 64'd3, 4'd0, 1'b1, 64'd3, 4'd0,
                 1'b0, 3'd0, 7'h00);
            tick();
        end
        idle();
        chk("pre_rst_occ", 64'(io.occupancy), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_occ", 64'(io.occupancy), 64'd0);
        chk("arst_valid", 64'(io.out_valid), 64'd0);
        chk("arst_data", io.out_data, 64'd0);
        chk("arst_tag", 64'(io.out_tag), 64'd0);
        chk("arst_alu", 64'(io.alu_lhs_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        io.out_ready = 1'b1;
        tick();
        chk("post_rst_valid", 64'(io.out_valid), 64'd0);
        chk("post_rst_occ", 64'(io.occupancy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Out-of-order issue buffer in front of the shared combinational ALU (alu, RV64 integer ops).
- Accepts dispatched ops whose operands may still be pending, and captures operands by tag from the common data bus (CDB).
- Each cycle, selects the oldest ready entry and drives it into the ALU.
- Registers the ALU result with its destination tag on a valid/ready output port toward writeback arbitration.

Parameters:
- DATA_WIDTH, 64, operand/result width; passed to alu.
- DEPTH, 4, number of entries (2..16).
- TAG_WIDTH, 4, width of physical/ROB tags.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all entries and the output register.
- dispatch_valid  in  1  dispatch request.
- dispatch_ready  out  1  entry free; dispatch accepted on valid&&ready at the edge.
- dispatch_tag  in  TAG_WIDTH  destination tag.
- dispatch_lhs / dispatch_rhs  in  DATA_WIDTH  operand values (meaningful when the matching _valid is high).
- dispatch_lhs_valid / dispatch_rhs_valid  in  1  operand already available.
- dispatch_lhs_tag / dispatch_rhs_tag  in  TAG_WIDTH  producer tag when the operand is pending.
- dispatch_uses_imm  in  1  forwarded to alu.uses_imm.
- dispatch_funct3  in  3  forwarded to alu.funct3.
- dispatch_funct7  in  7  forwarded to alu.funct7.
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  TAG_WIDTH  broadcast tag.
- cdb_data  in  DATA_WIDTH  broadcast value.
- alu_lhs, alu_rhs  out  DATA_WIDTH  to the ALU.
- alu_lhs_valid, alu_rhs_valid  out  1  to the ALU.
- alu_uses_imm  out  1  to the ALU.
- alu_funct3  out  3  to the ALU.
- alu_funct7  out  7  to the ALU.
- alu_result  in  DATA_WIDTH  from the ALU.
- alu_result_valid  in  1  from the ALU.
- out_valid  out  1  result register full.
- out_ready  in  1  consumer accepts.
- out_tag  out  TAG_WIDTH  destination tag of the result.
- out_data  out  DATA_WIDTH  result value.
- out_illegal  out  1  ALU rejected the encoding; out_data is 0.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset (async, rst_n low): all entries invalid; occupancy=0; out_valid=0, out_tag=0, out_data=0, out_illegal=0. ALU-side outputs are all 0 while no entry is selected.
- dispatch_ready = (occupancy != DEPTH), combinational. A freed slot is not reusable in the same cycle.
- Dispatch capture:
  - An operand is captured as ready if its dispatch _valid is high.
  - Otherwise, if cdb_valid && cdb_tag == operand tag in the same cycle, it is captured as ready with cdb_data (dispatch bypass).
  - Otherwise it is stored pending with its tag.
- Wakeup: at each edge, every valid entry's pending operand whose tag equals cdb_tag (cdb_valid high) latches cdb_data and becomes ready. Both operands of one entry may wake on the same broadcast.
- Ready = entry valid && both operands ready.
- Select: the oldest ready entry by dispatch order. Strict age order; ties are impossible. The implementation may shift or use an age matrix; the observable issue order is fixed.
- ALU drive (combinational from the selected entry): alu_lhs/alu_rhs/alu_uses_imm/alu_funct3/alu_funct7 = entry fields; alu_lhs_valid = alu_rhs_valid = 1. With no selection, all are 0.
- Issue condition: a selection exists && (!out_valid || out_ready) && !flush. On issue at the edge:
  - the entry is freed;
  - out_valid=1, out_tag=entry tag;
  - if alu_result_valid, out_data=alu_result and out_illegal=0; else out_data=0 and out_illegal=1.
- Output hold: when out_valid && !out_ready, the output register and all entries hold; wakeups still occur.
- Output drain: when out_valid && out_ready and no issue that cycle, out_valid=0 at the edge.
- Latency: an op dispatched with both operands ready at edge E0 is issued at E1, so out_valid is high in the cycle after E1. Minimum latency is 1 cycle in the station.
- An entry woken at edge E is selectable in the cycle after E.
- occupancy updates each edge: +1 on accepted dispatch, -1 on issue; both together leave it unchanged.
- Flush (synchronous, priority over everything):
  - all entries invalid and out_valid=0 at the next edge;
  - a same-cycle dispatch is dropped;
  - a same-cycle issue is suppressed.
- Reset mid-operation discards everything immediately; no partial output.
- Tags are not checked for uniqueness. A CDB broadcast wakes every matching pending operand.

Test Plan:
- Basic issue: dispatch ADD (funct3=0, funct7=0x00), lhs=5, rhs=7, both valid -> out_valid one cycle after acceptance, out_data=12, out_tag=dispatch_tag, out_illegal=0; occupancy goes 1 then 0.
- Dependent wakeup: dispatch SUB (funct7=0x20), lhs=100 valid, rhs pending tag 3. Two cycles later, CDB tag 3 data 40 -> out_data=60 one cycle after the broadcast; no issue before it.
- Dispatch bypass and age order:
  - entry A (tag 1) waits on tag 9; entry B (tag 2) is ready;
  - B issues first;
  - then CDB tag 9, concurrent with dispatching C (tag 4) waiting on tag 9 -> A and C both wake; A issues before C.
- Full and backpressure: hold out_ready=0 and dispatch DEPTH ready ops -> dispatch_ready=0, occupancy=DEPTH, out register holds the first result stably. Release out_ready -> results drain one per cycle in dispatch order.
- Illegal encoding: funct3=0, funct7=0x7f, uses_imm=0 -> out_valid=1, out_illegal=1, out_data=0.
- Flush and reset: with 3 entries and out_valid=1, assert flush together with a dispatch -> next cycle occupancy=0, out_valid=0, dispatched op absent. Repeat with rst_n pulsed low mid-cycle -> outputs clear immediately, without waiting for an edge.
